ddr2_clk_rdy_seq: RTL and testbench

- Consumer side of the 200 MHz clock / IDELAYCTRL bring-up.
- Monitors DCM lock and IDELAYCTRL ready, then sequences the DDR2 controller out of reset and handshakes its init.
- Re-runs the clock bring-up on timeout or lock loss, up to a retry limit, then declares a sticky fault.
- Sits in the clk_100MHz domain between the x2 clock generator / IDELAY control and the DDR2 memory controller.

---
 rtl/ddr2_pkg.sv | 24 ++
 rtl/sync_bit.sv | 28 ++
 rtl/ddr2_clk_rdy_seq.sv | 145 ++++++++++++++
 tb/tb_ddr2_clk_rdy_seq.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr2_pkg.sv
// Shared definitions for the DDR2 clock-ready sequencer: state encoding and
// default timing constants in clk_100MHz cycles.
package ddr2_pkg;

  typedef enum logic [2:0] {
    DCM_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    WAIT_IDLY = 3'd2,
    SETTLE    = 3'd3,
    INIT      = 3'd4,
    RUN       = 3'd5,
    FAULT     = 3'd6
  } state_t;

  localparam int SYNC_STAGES_DEF    = 2;
  localparam int DCM_RST_CYCLES_DEF = 16;
  localparam int LOCK_TIMEOUT_DEF   = 20000;
  localparam int RDY_TIMEOUT_DEF    = 2000;
  localparam int SETTLE_CYCLES_DEF  = 64;
  localparam int INIT_TIMEOUT_DEF   = 1000000;
  localparam int MAX_RETRY_DEF      = 3;
  localparam int CNT_W_DEF          = 20;

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level into clk_100MHz.
module sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_100MHz,
  input  logic rst_b,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_d;
  logic [SYNC_STAGES-1:0] sync_q;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk_100MHz or negedge rst_b) begin
    if (!rst_b) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ddr2_clk_rdy_seq.sv
// Brings the x2 DCM and IDELAYCTRL up, releases the DDR2 controller and
// handshakes its init; retries bring-up on failure, then latches a fault.
module ddr2_clk_rdy_seq
  import ddr2_pkg::*;
#(
  parameter int SYNC_STAGES    = SYNC_STAGES_DEF,
  parameter int DCM_RST_CYCLES = DCM_RST_CYCLES_DEF,
  parameter int LOCK_TIMEOUT   = LOCK_TIMEOUT_DEF,
  parameter int RDY_TIMEOUT    = RDY_TIMEOUT_DEF,
  parameter int SETTLE_CYCLES  = SETTLE_CYCLES_DEF,
  parameter int INIT_TIMEOUT   = INIT_TIMEOUT_DEF,
  parameter int MAX_RETRY      = MAX_RETRY_DEF,
  parameter int CNT_W          = CNT_W_DEF
) (
  input  logic       clk_100MHz,
  input  logic       rst_b,
  input  logic       dcm_locked,
  input  logic       idelay_rdy,
  input  logic       init_done,
  output logic       dcm_rst,
  output logic       ctrl_rst_b,
  output logic       init_start,
  output logic       sys_ready,
  output logic       fault,
  output logic [1:0] retry_cnt
);

  logic lk;
  logic ir;

  sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lk (
    .clk_100MHz (clk_100MHz),
    .rst_b      (rst_b),
    .d          (dcm_locked),
    .q          (lk)
  );

  sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ir (
    .clk_100MHz (clk_100MHz),
    .rst_b      (rst_b),
    .d          (idelay_rdy),
    .q          (ir)
  );

  state_t           state_d, state_q;
  logic [CNT_W-1:0] timer_d, timer_q;
  logic [1:0]       retry_cnt_d, retry_cnt_q;
  logic             dcm_rst_d, dcm_rst_q;
  logic             ctrl_rst_b_d, ctrl_rst_b_q;
  logic             init_start_d, init_start_q;
  logic             sys_ready_d, sys_ready_q;
  logic             fault_d, fault_q;
  logic             fail;

  always_comb begin
    state_d     = state_q;
    retry_cnt_d = retry_cnt_q;
    fail        = 1'b0;

    // Branch order encodes priority: lock loss, then ready, then timeout.
    case (state_q)
      DCM_RST: begin
        if (timer_q == CNT_W'(DCM_RST_CYCLES - 1)) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lk)                                         state_d = WAIT_IDLY;
        else if (timer_q == CNT_W'(LOCK_TIMEOUT - 1))   fail    = 1'b1;
      end
      WAIT_IDLY: begin
        if (!lk)                                        fail    = 1'b1;
        else if (ir)                                    state_d = SETTLE;
        else if (timer_q == CNT_W'(RDY_TIMEOUT - 1))    fail    = 1'b1;
      end
      SETTLE: begin
        if (!lk)                                        fail    = 1'b1;
        else if (!ir)                                   state_d = WAIT_IDLY;
        else if (timer_q == CNT_W'(SETTLE_CYCLES - 1))  state_d = INIT;
      end
      INIT: begin
        if (!lk || !ir)                                 fail    = 1'b1;
        else if (init_done)                             state_d = RUN;
        else if (timer_q == CNT_W'(INIT_TIMEOUT - 1))   fail    = 1'b1;
      end
      RUN: begin
        if (!lk || !ir)                                 fail    = 1'b1;
      end
      FAULT: ;
      default: state_d = DCM_RST;
    endcase

    if (fail) begin
      if (retry_cnt_q == 2'(MAX_RETRY - 1)) begin
        state_d     = FAULT;
        retry_cnt_d = 2'(MAX_RETRY);
      end else begin
        state_d     = DCM_RST;
        retry_cnt_d = retry_cnt_q + 2'd1;
      end
    end

    // RUN and FAULT have no timeout, so the timer is parked there.
    if ((state_d != state_q) || (state_q == RUN) || (state_q == FAULT)) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + CNT_W'(1);
    end

    // Outputs follow the next state so they change in the same cycle as it.
    dcm_rst_d    = (state_d == DCM_RST) || (state_d == FAULT);
    ctrl_rst_b_d = (state_d == INIT) || (state_d == RUN);
    init_start_d = (state_d == INIT) && (state_q == SETTLE);
    sys_ready_d  = (state_d == RUN);
    fault_d      = (state_d == FAULT);
  end

  always_ff @(posedge clk_100MHz or negedge rst_b) begin
    if (!rst_b) begin
      state_q      <= DCM_RST;
      timer_q      <= '0;
      retry_cnt_q  <= 2'd0;
      dcm_rst_q    <= 1'b1;
      ctrl_rst_b_q <= 1'b0;
      init_start_q <= 1'b0;
      sys_ready_q  <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      retry_cnt_q  <= retry_cnt_d;
      dcm_rst_q    <= dcm_rst_d;
      ctrl_rst_b_q <= ctrl_rst_b_d;
      init_start_q <= init_start_d;
      sys_ready_q  <= sys_ready_d;
      fault_q      <= fault_d;
    end
  end

  assign dcm_rst    = dcm_rst_q;
  assign ctrl_rst_b = ctrl_rst_b_q;
  assign init_start = init_start_q;
  assign sys_ready  = sys_ready_q;
  assign fault      = fault_q;
  assign retry_cnt  = retry_cnt_q;

endmodule

// File: tb/tb_ddr2_clk_rdy_seq.sv
// Bench for ddr2_clk_rdy_seq with shortened timeouts: table vectors, directed
// corner sequences and random input traffic against a deadline-based model.
module tb_ddr2_clk_rdy_seq;

  localparam int S      = 2;
  localparam int DCM_N  = 16;
  localparam int LOCK_T = 200;
  localparam int RDY_T  = 100;
  localparam int SET_N  = 64;
  localparam int INIT_T = 300;
  localparam int MAXR   = 3;

  logic       clk = 1'b0;
  logic       rst_b = 1'b1;
  logic       dcm_locked = 1'b0;
  logic       idelay_rdy = 1'b0;
  logic       init_done = 1'b0;
  logic       dcm_rst, ctrl_rst_b, init_start, sys_ready, fault;
  logic [1:0] retry_cnt;

  int checks = 0;
  int errors = 0;

  ddr2_clk_rdy_seq #(
    .SYNC_STAGES(S), .DCM_RST_CYCLES(DCM_N), .LOCK_TIMEOUT(LOCK_T),
    .RDY_TIMEOUT(RDY_T), .SETTLE_CYCLES(SET_N), .INIT_TIMEOUT(INIT_T),
    .MAX_RETRY(MAXR), .CNT_W(20)
  ) dut (
    .clk_100MHz (clk),
    .rst_b      (rst_b),
    .dcm_locked (dcm_locked),
    .idelay_rdy (idelay_rdy),
    .init_done  (init_done),
    .dcm_rst    (dcm_rst),
    .ctrl_rst_b (ctrl_rst_b),
    .init_start (init_start),
    .sys_ready  (sys_ready),
    .fault      (fault),
    .retry_cnt  (retry_cnt)
  );

  always #5 clk = ~clk;

  // Packed view: {dcm_rst, ctrl_rst_b, init_start, sys_ready, fault, retry_cnt}
  function automatic logic [6:0] pack();
    return {dcm_rst, ctrl_rst_b, init_start, sys_ready, fault, retry_cnt};
  endfunction

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", name, act, exp);
    end
  endtask

  // Reference model: phase plus absolute deadline edge, edges counted from reset release.
  typedef enum {M_RST, M_LOCK, M_IDLY, M_SETTLE, M_INIT, M_RUN, M_FAULT} mph_t;
  mph_t ph;
  int   cyc, t_entry, deadline, fails;
  bit   lkq[$];
  bit   irq[$];

  function automatic void m_enter(mph_t p, int limit);
    ph       = p;
    t_entry  = cyc;
    deadline = cyc + limit;
  endfunction

  function automatic void m_fail();
    if (fails == MAXR - 1) begin
      fails = MAXR;
      m_enter(M_FAULT, 0);
    end else begin
      fails = fails + 1;
      m_enter(M_RST, DCM_N);
    end
  endfunction

  function automatic void m_reset();
    cyc = 0;
    fails = 0;
    m_enter(M_RST, DCM_N);
    lkq = {};
    irq = {};
    for (int i = 0; i < S; i++) begin
      lkq.push_back(1'b0);
      irq.push_back(1'b0);
    end
  endfunction

  function automatic void m_step();
    bit lk, ir;
    cyc = cyc + 1;
    lk = lkq.pop_front();
    ir = irq.pop_front();
    lkq.push_back(dcm_locked);
    irq.push_back(idelay_rdy);
    case (ph)
      M_RST:    if (cyc == deadline) m_enter(M_LOCK, LOCK_T);
      M_LOCK:   if (lk) m_enter(M_IDLY, RDY_T);
                else if (cyc == deadline) m_fail();
      M_IDLY:   if (!lk) m_fail();
                else if (ir) m_enter(M_SETTLE, SET_N);
                else if (cyc == deadline) m_fail();
      M_SETTLE: if (!lk) m_fail();
                else if (!ir) m_enter(M_IDLY, RDY_T);
                else if (cyc == deadline) m_enter(M_INIT, INIT_T);
      M_INIT:   if (!lk || !ir) m_fail();
                else if (init_done) m_enter(M_RUN, 0);
                else if (cyc == deadline) m_fail();
      M_RUN:    if (!lk || !ir) m_fail();
      default: ;
    endcase
  endfunction

  function automatic logic [6:0] m_exp();
    return {ph == M_RST || ph == M_FAULT, ph == M_INIT || ph == M_RUN,
            ph == M_INIT && t_entry == cyc, ph == M_RUN, ph == M_FAULT, 2'(fails)};
  endfunction

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      m_step();
      @(negedge clk);
      chk($sformatf("model_c%0d", cyc), pack(), m_exp());
    end
  endtask

  // Called at a falling edge; asserts reset mid-cycle and checks it acts at once.
  task automatic do_reset(input string name);
    #2 rst_b = 1'b0;
    #1 chk(name, pack(), 7'b1000000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    m_reset();
  endtask

  task automatic set_in(input logic lk, input logic ir, input logic dn);
    dcm_locked = lk;
    idelay_rdy = ir;
    init_done  = dn;
  endtask

  typedef struct {
    int         n;
    logic       lk;
    logic       ir;
    logic       dn;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl[10];

  initial begin
    // Nominal bring-up: lock at edge 30, idelay at edge 50, init_done 100 after init_start.
    tbl[0] = '{15, 1'b0, 1'b0, 1'b0, 7'b1000000};
    tbl[1] = '{1,  1'b0, 1'b0, 1'b0, 7'b0000000};
    tbl[2] = '{13, 1'b0, 1'b0, 1'b0, 7'b0000000};
    tbl[3] = '{20, 1'b1, 1'b0, 1'b0, 7'b0000000};
    tbl[4] = '{66, 1'b1, 1'b1, 1'b0, 7'b0000000};
    tbl[5] = '{1,  1'b1, 1'b1, 1'b0, 7'b0110000};
    tbl[6] = '{1,  1'b1, 1'b1, 1'b0, 7'b0100000};
    tbl[7] = '{98, 1'b1, 1'b1, 1'b0, 7'b0100000};
    tbl[8] = '{1,  1'b1, 1'b1, 1'b1, 7'b0101000};
    tbl[9] = '{5,  1'b1, 1'b1, 1'b0, 7'b0101000};

    @(negedge clk);
    set_in(1'b0, 1'b0, 1'b0);
    do_reset("reset_values");
    for (int r = 0; r < 10; r++) begin
      set_in(tbl[r].lk, tbl[r].ir, tbl[r].dn);
      run(tbl[r].n);
      chk($sformatf("nominal_row%0d", r), pack(), tbl[r].exp);
    end

    // Lock drop while running, then a full resequence back to RUN.
    set_in(1'b0, 1'b1, 1'b0);
    run(3);
    chk("lockdrop_fall", pack(), 7'b1000001);
    set_in(1'b1, 1'b1, 1'b1);
    run(200);
    chk("lockdrop_rerun", pack(), 7'b0101001);

    // Lock never arrives: three attempts, then sticky fault.
    set_in(1'b0, 1'b0, 1'b0);
    do_reset("nolock_reset");
    run(215); chk("nolock_wait1", pack(), 7'b0000000);
    run(1);   chk("nolock_fail1", pack(), 7'b1000001);
    run(215); chk("nolock_wait2", pack(), 7'b0000001);
    run(1);   chk("nolock_fail2", pack(), 7'b1000010);
    run(216); chk("nolock_fault", pack(), 7'b1000111);
    run(50);  chk("nolock_sticky", pack(), 7'b1000111);
    do_reset("nolock_clear");

    // One-cycle idelay glitch in SETTLE restarts the settle count.
    set_in(1'b1, 1'b1, 1'b0);
    run(39);
    idelay_rdy = 1'b0;
    run(1);
    idelay_rdy = 1'b1;
    run(42); chk("glitch_old_end", pack(), 7'b0000000);
    run(24); chk("glitch_pre_init", pack(), 7'b0000000);
    run(1);  chk("glitch_init", pack(), 7'b0110000);

    // init_done withheld: INIT timeout, then init_done on the last timeout cycle.
    set_in(1'b1, 1'b1, 1'b0);
    do_reset("initto_reset");
    run(81);  chk("initto_pre", pack(), 7'b0000000);
    run(1);   chk("initto_start", pack(), 7'b0110000);
    run(299); chk("initto_last", pack(), 7'b0100000);
    run(1);   chk("initto_fail", pack(), 7'b1000001);
    run(381); chk("initto_edge_pre", pack(), 7'b0100001);
    init_done = 1'b1;
    run(1);   chk("initto_edge_run", pack(), 7'b0101001);
    init_done = 1'b0;
    run(5);

    // Asynchronous reset in INIT, then a clean restart.
    do_reset("init_rst_prep");
    run(90);
    chk("in_init", pack(), 7'b0100000);
    do_reset("init_async_rst");
    run(15);  chk("restart_dcm", pack(), 7'b1000000);
    run(1);   chk("restart_lock", pack(), 7'b0000000);
    init_done = 1'b1;
    run(100); chk("restart_run", pack(), 7'b0101000);

    // Random traffic: slowly toggling readies, sparse init_done.
    for (int ep = 0; ep < 12; ep++) begin
      int flip_lk, flip_ir, dn_rate;
      flip_lk = (ep % 3 == 2) ? 60 : 400;
      flip_ir = (ep % 3 == 1) ? 50 : 300;
      dn_rate = (ep % 4 == 3) ? 4000 : 40;
      set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      do_reset($sformatf("rand_reset%0d", ep));
      for (int i = 0; i < 1500; i++) begin
        if ($urandom_range(0, flip_lk - 1) == 0) dcm_locked = ~dcm_locked;
        if ($urandom_range(0, flip_ir - 1) == 0) idelay_rdy = ~idelay_rdy;
        init_done = ($urandom_range(0, dn_rate - 1) < 3) ? 1'b1 : 1'b0;
        run(1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
